uart_boot_loader: RTL

Power-on boot sequencer for the 16-bit computer. Out of reset it owns the RAM port and holds the CPU. It programs the t16450 UART for 8N1 at a fixed divisor, then polls the UART over its register interface and receives a length-prefixed, checksummed image. It writes the image into RAM as 16-bit words, then releases the RAM bus and the CPU. It sits between the UART register port and the memory_io RAM side; the top level muxes RAM and UART control with `bus_grant`.

---
 rtl/boot_pkg.sv | 40 ++++
 rtl/uart_byte_poller.sv | 60 ++++++
 rtl/uart_boot_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: sequencer states, t16450
// register map and the line-control / line-status constants it relies on.
package boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_DLAB,
        ST_INIT_DLL,
        ST_INIT_DLM,
        ST_INIT_LCR,
        ST_INIT_IER,
        ST_RX_LEN_LO,
        ST_RX_LEN_HI,
        ST_RX_DAT_LO,
        ST_RX_DAT_HI,
        ST_STORE,
        ST_RX_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_LSR_RD,
        P_LSR_CAP,
        P_RBR_RD,
        P_RBR_CAP
    } poll_state_t;

    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER_DLM = 3'd1;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] LSR     = 3'd5;

    localparam logic [7:0] LCR_DLAB = 8'h80;
    localparam logic [7:0] LCR_8N1  = 8'h03;

    localparam int LSR_DR = 0;

endpackage

// File: rtl/uart_byte_poller.sv
// Fetches one received byte from the UART on request: polls LSR until data
// ready, then reads RBR and presents the byte with a one-cycle valid pulse.
module uart_byte_poller
    import boot_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       get,
    input  logic [7:0] rdata,
    output logic [2:0] rd_addr,
    output logic       rd_strobe,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    poll_state_t state;

    // Read data is valid the cycle after the strobe, so each read spends
    // one cycle strobing and one cycle capturing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= P_IDLE;
            rd_addr    <= 3'd0;
            rd_strobe  <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            rd_addr    <= 3'd0;
            rd_strobe  <= 1'b0;
            byte_valid <= 1'b0;
            case (state)
                P_IDLE: begin
                    if (get) begin
                        rd_strobe <= 1'b1;
                        rd_addr   <= LSR;
                        state     <= P_LSR_RD;
                    end
                end
                P_LSR_RD:  state <= P_LSR_CAP;
                P_LSR_CAP: begin
                    rd_strobe <= 1'b1;
                    if (rdata[LSR_DR]) begin
                        rd_addr <= RBR_THR;
                        state   <= P_RBR_RD;
                    end else begin
                        rd_addr <= LSR;
                        state   <= P_LSR_RD;
                    end
                end
                P_RBR_RD:  state <= P_RBR_CAP;
                P_RBR_CAP: begin
                    byte_data  <= rdata;
                    byte_valid <= 1'b1;
                    state      <= P_IDLE;
                end
                default:   state <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Power-on boot sequencer: configures the UART, receives a length-prefixed
// checksummed image into RAM, then hands the bus and the CPU over.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loader_en,
    output logic [2:0]  uart_addr,
    output logic [7:0]  uart_wdata,
    output logic        uart_we,
    output logic        uart_re,
    input  logic [7:0]  uart_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic        bus_grant,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    boot_state_t state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] waddr;
    logic [7:0]  sum;
    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr;
    logic        rd_strobe;
    logic        get;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] len_full;
    logic        rx_state;

    assign rx_state = (state == ST_RX_LEN_LO) || (state == ST_RX_LEN_HI) ||
                      (state == ST_RX_DAT_LO) || (state == ST_RX_DAT_HI) ||
                      (state == ST_RX_CSUM);
    // Masking with byte_valid keeps the poller from starting a fetch for a
    // field the sequencer is just leaving.
    assign get       = rx_state && !byte_valid;
    assign len_full  = {byte_data, len[7:0]};
    assign uart_addr = wr_addr | rd_addr;
    assign uart_re   = rd_strobe;

    uart_byte_poller u_poller (
        .clk        (clk),
        .reset      (reset),
        .get        (get),
        .rdata      (uart_rdata),
        .rd_addr    (rd_addr),
        .rd_strobe  (rd_strobe),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len        <= 16'd0;
            cnt        <= 16'd0;
            waddr      <= 16'd0;
            sum        <= 8'd0;
            wr_addr    <= 3'd0;
            uart_wdata <= 8'd0;
            uart_we    <= 1'b0;
            ram_addr   <= 16'd0;
            ram_wdata  <= 16'd0;
            ram_we     <= 1'b0;
            ram_be     <= 2'b00;
            bus_grant  <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_addr    <= 3'd0;
            uart_wdata <= 8'd0;
            uart_we    <= 1'b0;
            ram_we     <= 1'b0;
            ram_be     <= 2'b00;
            case (state)
                ST_IDLE: begin
                    cnt   <= 16'd0;
                    sum   <= 8'd0;
                    waddr <= BASE_ADDR;
                    state <= loader_en ? ST_INIT_DLAB : ST_DONE;
                end
                ST_INIT_DLAB: begin
                    uart_we    <= 1'b1;
                    wr_addr    <= LCR;
                    uart_wdata <= LCR_DLAB;
                    state      <= ST_INIT_DLL;
                end
                ST_INIT_DLL: begin
                    uart_we    <= 1'b1;
                    wr_addr    <= RBR_THR;
                    uart_wdata <= DIVISOR[7:0];
                    state      <= ST_INIT_DLM;
                end
                ST_INIT_DLM: begin
                    uart_we    <= 1'b1;
                    wr_addr    <= IER_DLM;
                    uart_wdata <= DIVISOR[15:8];
                    state      <= ST_INIT_LCR;
                end
                ST_INIT_LCR: begin
                    uart_we    <= 1'b1;
                    wr_addr    <= LCR;
                    uart_wdata <= LCR_8N1;
                    state      <= ST_INIT_IER;
                end
                ST_INIT_IER: begin
                    uart_we    <= 1'b1;
                    wr_addr    <= IER_DLM;
                    uart_wdata <= 8'h00;
                    state      <= ST_RX_LEN_LO;
                end
                ST_RX_LEN_LO: begin
                    if (byte_valid) begin
                        len[7:0] <= byte_data;
                        state    <= ST_RX_LEN_HI;
                    end
                end
                ST_RX_LEN_HI: begin
                    if (byte_valid) begin
                        len <= len_full;
                        if (len_full == 16'd0) begin
                            state <= ST_RX_CSUM;
                        end else if (len_full > MAX_WORDS) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= ST_RX_DAT_LO;
                        end
                    end
                end
                ST_RX_DAT_LO: begin
                    if (byte_valid) begin
                        lo_byte <= byte_data;
                        sum     <= sum + byte_data;
                        state   <= ST_RX_DAT_HI;
                    end
                end
                ST_RX_DAT_HI: begin
                    if (byte_valid) begin
                        hi_byte <= byte_data;
                        sum     <= sum + byte_data;
                        state   <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    ram_we    <= 1'b1;
                    ram_be    <= 2'b11;
                    ram_addr  <= waddr;
                    ram_wdata <= {hi_byte, lo_byte};
                    waddr     <= waddr + 16'd2;
                    cnt       <= cnt + 16'd1;
                    state     <= (cnt == len - 16'd1) ? ST_RX_CSUM : ST_RX_DAT_LO;
                end
                // Release happens on the capture edge of the checksum byte.
                ST_RX_CSUM: begin
                    if (byte_valid) begin
                        if (byte_data == sum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            bus_grant <= 1'b0;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    bus_grant <= 1'b0;
                    cpu_hold  <= 1'b0;
                end
                ST_ERR: begin
                    error     <= 1'b1;
                    bus_grant <= 1'b1;
                    cpu_hold  <= 1'b1;
                end
                default: begin
                    state <= ST_ERR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule
